alu_flags_stage: RTL and testbench

Registered ALU stage directly downstream of the barrel shifter. It takes operand A from the register file and operand B plus the shifter carry from the shifter outputs, and executes the 16 ARM-style data-processing operations. It holds the NZCV flag register, whose C bit feeds back to the shifter's `CF` input. It also runs an optional iterative 32×32 multiply. Results are presented to write-back through a valid/ready handshake.

---
 rtl/alu_flags_stage.sv | 165 ++++++++++++++++
 tb/tb_alu_flags_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flags_stage.sv
// Registered ARM-style ALU stage with NZCV flag register and valid/ready result handshake.
// Define ALU_MUL_EN to include the iterative 32x32 shift-add multiplier (Op_Mul).
module alu_flags_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [3:0]       ALU_OP,
  input  logic             Op_Mul,
  input  logic             S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Shift_Carry,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] F,
  output logic             Wr_En,
  output logic [3:0]       NZCV,
  output logic             CF
);

  localparam logic [3:0] OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_MUL} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_HOLD} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_f;
  logic             r_wr;
  logic             r_valid;
  logic [3:0]       r_nzcv;

  logic [WIDTH-1:0] w_x, w_y, w_logic, w_res;
  logic [WIDTH:0]   w_sum;
  logic             w_cin, w_arith, w_wr, w_c, w_v;
  logic [3:0]       w_nzcv_next;
  logic             w_accept;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
  logic [5:0]       r_cnt;
  logic             r_mul_s;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
`else
  logic w_unused_op_mul;
  assign w_unused_op_mul = Op_Mul;
`endif

  assign In_Ready  = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & Out_Ready);
  assign w_accept  = In_Valid & In_Ready;
  assign F         = r_f;
  assign Wr_En     = r_wr;
  assign Out_Valid = r_valid;
  assign NZCV      = r_nzcv;
  assign CF        = r_nzcv[1];

  // Subtracts are folded into one 33-bit adder as x + ~y + cin.
  always_comb begin
    w_x     = A;
    w_y     = B;
    w_cin   = 1'b0;
    w_arith = 1'b0;
    w_logic = A & B;
    w_wr    = 1'b1;
    case (ALU_OP)
      OP_AND: w_logic = A & B;
      OP_EOR: w_logic = A ^ B;
      OP_SUB: begin w_arith = 1'b1; w_y = ~B; w_cin = 1'b1; end
      OP_RSB: begin w_arith = 1'b1; w_x = B; w_y = ~A; w_cin = 1'b1; end
      OP_ADD: w_arith = 1'b1;
      OP_ADC: begin w_arith = 1'b1; w_cin = r_nzcv[1]; end
      OP_SBC: begin w_arith = 1'b1; w_y = ~B; w_cin = r_nzcv[1]; end
      OP_RSC: begin w_arith = 1'b1; w_x = B; w_y = ~A; w_cin = r_nzcv[1]; end
      OP_TST: begin w_logic = A & B; w_wr = 1'b0; end
      OP_TEQ: begin w_logic = A ^ B; w_wr = 1'b0; end
      OP_CMP: begin w_arith = 1'b1; w_y = ~B; w_cin = 1'b1; w_wr = 1'b0; end
      OP_CMN: begin w_arith = 1'b1; w_wr = 1'b0; end
      OP_ORR: w_logic = A | B;
      OP_MOV: w_logic = B;
      OP_BIC: w_logic = A & ~B;
      default: w_logic = ~B;
    endcase
    w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
    w_res = w_arith ? w_sum[WIDTH-1:0] : w_logic;
    w_c   = w_arith ? w_sum[WIDTH] : Shift_Carry;
    w_v   = w_arith ? ((w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]))
                    : r_nzcv[0];
    w_nzcv_next = S ? {w_res[WIDTH-1], (w_res == '0), w_c, w_v} : r_nzcv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_f     <= '0;
      r_wr    <= 1'b0;
      r_valid <= 1'b0;
      r_nzcv  <= '0;
`ifdef ALU_MUL_EN
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_mul_s  <= 1'b0;
`endif
    end else begin
      case (r_state)
`ifdef ALU_MUL_EN
        // One multiplier bit per edge; the last step writes the result directly.
        ST_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_f     <= w_acc_next;
            r_wr    <= 1'b1;
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
            if (r_mul_s) begin
              r_nzcv[3] <= w_acc_next[WIDTH-1];
              r_nzcv[2] <= (w_acc_next == '0);
            end
          end
        end
`endif
        default: begin
          if (w_accept) begin
`ifdef ALU_MUL_EN
            if (Op_Mul) begin
              r_mcand  <= A;
              r_mplier <= B;
              r_acc    <= '0;
              r_cnt    <= 6'(WIDTH);
              r_mul_s  <= S;
              r_valid  <= 1'b0;
              r_state  <= ST_MUL;
            end else
`endif
            begin
              r_f     <= w_res;
              r_wr    <= w_wr;
              r_nzcv  <= w_nzcv_next;
              r_valid <= 1'b1;
              r_state <= ST_HOLD;
            end
          end else if ((r_state == ST_HOLD) && Out_Ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_flags_stage.sv
// Bench for alu_flags_stage: directed vectors plus randomized ops against an arithmetic reference model.
// Multiply checks are compiled in when ALU_MUL_EN is defined.
module tb_alu_flags_stage;

  logic        clk = 1'b0;
  logic        rst_n, In_Valid, Op_Mul, S, Shift_Carry, Out_Ready;
  logic [3:0]  ALU_OP;
  logic [31:0] A, B;
  logic        In_Ready, Out_Valid, Wr_En, CF;
  logic [31:0] F;
  logic [3:0]  NZCV;

  int          checks = 0;
  int          failures = 0;
  logic [3:0]  exp_nzcv;
  logic [31:0] exp_f;
  logic        exp_wr;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  alu_flags_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .ALU_OP(ALU_OP), .Op_Mul(Op_Mul), .S(S), .A(A), .B(B), .Shift_Carry(Shift_Carry),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .F(F), .Wr_En(Wr_En), .NZCV(NZCV), .CF(CF)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: results from plain signed/unsigned 64-bit arithmetic on the operands.
  task automatic model(input logic [3:0] op, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic sc, input logic [3:0] nz,
                       output logic [31:0] f, output logic wr, output logic [3:0] nzo);
    longint ua, ub, u, sa, sb, sv;
    longint cin;
    int     kind;
    logic [31:0] p, q;
    logic   c, v;
    kind = 0; p = a; q = b; c = sc; v = nz[0]; f = '0;
    cin = nz[1] ? 1 : 0;
    case (op)
      0, 8:  f = a & b;
      1, 9:  f = a ^ b;
      12:    f = a | b;
      13:    f = b;
      14:    f = a & ~b;
      15:    f = ~b;
      4, 11: begin kind = 1; cin = 1; cin = 0; end
      5:     kind = 1;
      2, 10: begin kind = 2; cin = 1; end
      3:     begin kind = 2; p = b; q = a; cin = 1; end
      6:     kind = 2;
      7:     begin kind = 2; p = b; q = a; end
      default: ;
    endcase
    ua = p; ub = q;
    sa = $signed(p); sb = $signed(q);
    if (kind == 1) begin
      u  = ua + ub + cin;
      sv = sa + sb + cin;
      f  = u[31:0];
      c  = (u > 64'sd4294967295);
      v  = (sv > MAXS) || (sv < MINS);
    end else if (kind == 2) begin
      u  = ua - ub - (1 - cin);
      sv = sa - sb - (1 - cin);
      f  = u[31:0];
      c  = (u >= 0);
      v  = (sv > MAXS) || (sv < MINS);
    end
    wr  = !(op >= 4'd8 && op <= 4'd11);
    nzo = s ? {f[31], (f == 32'd0), c, v} : nz;
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, Out_Valid, 1'b1);
    chk({tag, ".f"}, F, exp_f);
    chk({tag, ".wr"}, Wr_En, exp_wr);
    chk({tag, ".nzcv"}, NZCV, exp_nzcv);
    chk({tag, ".cf"}, CF, exp_nzcv[1]);
  endtask

  // Called at a falling edge with the DUT in IDLE or HOLD; accepts on the next rising edge.
  task automatic do_op(input logic [3:0] op, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic sc, input logic m);
    logic [31:0] ef; logic ew; logic [3:0] en;
    model(op, s, a, b, sc, exp_nzcv, ef, ew, en);
    In_Valid = 1'b1; ALU_OP = op; S = s; A = a; B = b; Shift_Carry = sc; Op_Mul = m; Out_Ready = 1'b1;
    #1 chk($sformatf("op%0d.in_ready", op), In_Ready, 1'b1);
    @(posedge clk); @(negedge clk);
    In_Valid = 1'b0; Op_Mul = 1'b0;
    exp_f = ef; exp_wr = ew; exp_nzcv = en;
    check_outputs($sformatf("op%0d", op));
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      Out_Ready = 1'b0;
      In_Valid = 1'($urandom_range(0, 1));
      ALU_OP = 4'($urandom); A = $urandom; B = $urandom;
      #1 chk("stall.in_ready", In_Ready, 1'b0);
      @(posedge clk); @(negedge clk);
      check_outputs("stall");
    end
    In_Valid = 1'b0;
  endtask

  task automatic drain();
    Out_Ready = 1'b1; In_Valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("drain.valid", Out_Valid, 1'b0);
    chk("drain.in_ready", In_Ready, 1'b1);
  endtask

`ifdef ALU_MUL_EN
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    int   lat;
    logic ready_bad;
    In_Valid = 1'b1; Op_Mul = 1'b1; ALU_OP = 4'($urandom); S = s; A = a; B = b; Out_Ready = 1'b1;
    #1 chk("mul.in_ready", In_Ready, 1'b1);
    @(posedge clk); @(negedge clk);
    Op_Mul = 1'b0; ALU_OP = 4'd4; A = $urandom; B = $urandom;
    exp_f = a * b; exp_wr = 1'b1;
    if (s) exp_nzcv[3:2] = {exp_f[31], (exp_f == 32'd0)};
    lat = 0; ready_bad = 1'b0;
    while (!Out_Valid && lat < 40) begin
      Out_Ready = 1'($urandom_range(0, 1));
      #1 if (In_Ready !== 1'b0) ready_bad = 1'b1;
      @(posedge clk); @(negedge clk);
      lat++;
    end
    In_Valid = 1'b0;
    chk("mul.latency", lat, 32);
    chk("mul.in_ready_busy", ready_bad, 1'b0);
    check_outputs("mul");
  endtask
`endif

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, ".valid"}, Out_Valid, 1'b0);
    chk({tag, ".nzcv"}, NZCV, 4'b0000);
    chk({tag, ".f"}, F, 32'h0);
    chk({tag, ".wr"}, Wr_En, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_nzcv = 4'b0; exp_f = 32'h0; exp_wr = 1'b0;
    #1 chk({tag, ".in_ready"}, In_Ready, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; In_Valid = 1'b0; Op_Mul = 1'b0; S = 1'b0; Shift_Carry = 1'b0;
    Out_Ready = 1'b0; ALU_OP = 4'd0; A = '0; B = '0;
    exp_nzcv = 4'b0; exp_f = 32'h0; exp_wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.valid", Out_Valid, 1'b0);
    chk("rst.nzcv", NZCV, 4'b0000);
    chk("rst.f", F, 32'h0);
    chk("rst.wr", Wr_En, 1'b0);
    chk("rst.in_ready", In_Ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(4'd4, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("add_ovf.f", F, 32'h8000_0000);
    chk("add_ovf.nzcv", NZCV, 4'b1001);
    do_op(4'd5, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("adc_zero.f", F, 32'h0);
    chk("adc_zero.nzcv", NZCV, 4'b0100);
    do_op(4'd2, 1'b1, 32'd5, 32'd5, 1'b0, 1'b0);
    chk("sub_eq.nzcv", NZCV, 4'b0110);
    do_op(4'd10, 1'b1, 32'd3, 32'd5, 1'b0, 1'b0);
    chk("cmp_lt.nzcv", NZCV, 4'b1000);
    chk("cmp_lt.wr", Wr_En, 1'b0);
    do_op(4'd4, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    do_op(4'd13, 1'b1, 32'h1234, 32'h0, 1'b1, 1'b0);
    chk("mov_keepv.nzcv", NZCV, 4'b0111);
    do_op(4'd10, 1'b0, 32'd1, 32'd9, 1'b0, 1'b0);
    chk("cmp_nos.nzcv", NZCV, 4'b0111);
    chk("cmp_nos.wr", Wr_En, 1'b0);
    do_op(4'd2, 1'b1, 32'd5, 32'd3, 1'b0, 1'b0);
    do_op(4'd5, 1'b0, 32'd1, 32'd1, 1'b0, 1'b0);
    chk("adc_chain.f", F, 32'd3);

    do_op(4'd1, 1'b1, 32'hFF, 32'h0F, 1'b0, 1'b0);
    stall(3);
    chk("bp.f", F, 32'hF0);
    do_op(4'd12, 1'b1, 32'hA0, 32'h05, 1'b0, 1'b0);
    chk("bp_release.f", F, 32'hA5);
    drain();

`ifdef ALU_MUL_EN
    do_op(4'd4, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    do_mul(32'h0001_0001, 32'h0001_0001, 1'b1);
    chk("mul_spec.f", F, 32'h0002_0001);
    chk("mul_spec.nzcv", NZCV, 4'b0011);
    drain();
    In_Valid = 1'b1; Op_Mul = 1'b1; A = 32'd7; B = 32'd9; Out_Ready = 1'b1;
    @(posedge clk); @(negedge clk);
    In_Valid = 1'b0; Op_Mul = 1'b0;
    repeat (10) @(negedge clk);
    reset_pulse("rst_mul");
    begin
      logic seen;
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (Out_Valid !== 1'b0) seen = 1'b1;
      end
      chk("rst_mul.aborted", seen, 1'b0);
    end
`else
    do_op(4'd4, 1'b1, 32'd2, 32'd3, 1'b0, 1'b1);
    chk("opmul_ignored.f", F, 32'd5);
    reset_pulse("rst_hold");
`endif

    for (int it = 0; it < 150; it++) begin
`ifdef ALU_MUL_EN
      if ($urandom_range(0, 7) == 0) do_mul(rnd(), rnd(), 1'($urandom_range(0, 1)));
      else do_op(4'($urandom), 1'($urandom_range(0, 1)), rnd(), rnd(), 1'($urandom_range(0, 1)), 1'b0);
`else
      do_op(4'($urandom), 1'($urandom_range(0, 1)), rnd(), rnd(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
`endif
      if ($urandom_range(0, 3) == 0) stall($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
